cmd_issue_scheduler: RTL and testbench
======================================

Name: cmd_issue_scheduler

Overview:
- Arbitrates the six command buffers (restart, wed, write, read, prefetch_read, prefetch_write) for the single PSL command issue port.
- Tracks PSL command credits and grants at most one buffer per cycle.
- On a PAGED/flush event, enters restart-only mode so that only restart commands issue until the restart sequence completes.
- Sits between the command buffers and the command issue register in the AFU control path.

Parameters:
CREDIT_WIDTH, 9, width of the credit counter and credit_init; matches response_credits width.
PREFETCH_RESERVE, 4, prefetch classes are granted only when credits > PREFETCH_RESERVE.
NUM_REQ, 6, number of requester classes; fixed, not overridable.

Ports:
clock  in  1  core clock
rstn  in  1  synchronous active-low reset
enabled  in  1  scheduler enable; 0 suppresses all grants
credit_init  in  CREDIT_WIDTH  initial/maximum credits (ha_croom), sampled in ARB_INIT
request_in  in  6  level requests; bit0 restart, 1 wed, 2 write, 3 read, 4 prefetch_read, 5 prefetch_write
credit_return  in  1  one credit returned (a response consumed)
paged_flush  in  1  pulse; enter restart-only mode
restart_done  in  1  pulse; leave restart-only mode
grant_out  out  6  one-hot grant, same bit order; the granted buffer pops this cycle
issue_valid  out  1  high when any grant_out bit is set
credits_out  out  CREDIT_WIDTH  current available credits
restart_mode  out  1  1 while in ARB_RESTART_ONLY
credit_error  out  1  sticky; credit returned while counter is at credit_init

Behaviour:
- Reset (rstn=0 at a clock edge):
  - state=ARB_RESET; grant_out=0, issue_valid=0, credits_out=0, restart_mode=0, credit_error=0.
  - rr pointer=write.
- State machine:
  - ARB_RESET -> ARB_INIT unconditionally.
  - ARB_INIT: credits <= credit_init, cap <= credit_init; then -> ARB_RUN.
  - ARB_RUN -> ARB_RESTART_ONLY on paged_flush.
  - ARB_RESTART_ONLY -> ARB_RUN on restart_done.
  - If paged_flush and restart_done are asserted in the same cycle, paged_flush wins.
- Grant eligibility, ARB_RUN:
  - Requires enabled=1 and credits>0.
  - Priority: restart > wed > {write, read} round-robin > prefetch_read > prefetch_write.
  - Prefetch classes additionally require credits > PREFETCH_RESERVE.
- Grant eligibility, ARB_RESTART_ONLY: only bit0 (restart) is eligible; all other requests are held off.
- Round-robin: the rr pointer toggles only when write or read is granted, pointing to the other one. When only one of the pair requests, it is granted regardless of the pointer.
- Timing and handshake:
  - grant_out and issue_valid are registered: a request sampled at edge N produces its grant during cycle N+1.
  - Grants are computed from the registered credits value.
  - The scheduler never grants two cycles back-to-back to the same class unless that class is still requesting at the next evaluation. Requesters deassert in the cycle after a grant if their buffer empties; a stale request yields one extra grant, and the buffer ignores a pop when empty (buffer-side rule).
- Credits:
  - Counter -1 on each grant, +1 on credit_return; a simultaneous grant and return leaves it unchanged.
  - A return with credits==cap (and no grant in the same cycle) leaves credits unchanged and sets credit_error.
  - The counter never underflows, because a grant requires credits>0.
- enabled=0: no grants are issued; credits still accept returns; state transitions still occur.
- Reset mid-operation: any outstanding grant is dropped, the credit count is reloaded via ARB_INIT, and restart mode is cleared.
- Grant computation is evaluated in ARB_RUN and ARB_RESTART_ONLY only; ARB_RESET and ARB_INIT issue no grants.

Test Plan:
- Reset, credit_init=8, request_in=6'b000100 held -> no grant during reset/INIT; then grant_out=000100 every cycle; credits 8->0 over 8 grants; no grant with credits=0; one credit_return -> exactly one more grant.
- request_in=6'b001100 held, credit_init=16 -> grants alternate write, read, write, read; the first is write (rr reset value).
- request_in=6'b111111, credit_init=16 -> restart granted every cycle while held. Drop bit0 -> wed only. Drop bit1 -> write/read alternate; prefetch is never granted while write/read request.
- Only prefetch_read requesting, credit_init=6 -> grants at credits 6 and 5, then no grant at credits=4 (PREFETCH_RESERVE=4).
- paged_flush pulse with request_in=6'b001101 -> restart_mode=1, only bit0 granted. Drop restart and pulse restart_done -> restart_mode=0, write/read grants resume. paged_flush and restart_done in the same cycle -> restart_mode=1.
- credits at cap=8, credit_return=1 without a grant -> credits stay 8, credit_error=1 and stays 1 until rstn=0.

Source files
------------

// File: rtl/cmd_issue_scheduler.sv
// cmd_issue_scheduler: credit-tracked one-hot arbiter for the single PSL command issue port,
// with a restart-only mode entered on a paged/flush event.
module cmd_issue_scheduler #(
  parameter int CREDIT_WIDTH     = 9,
  parameter int PREFETCH_RESERVE = 4
) (
  input  logic                    i_clock,
  input  logic                    i_rstn,
  input  logic                    i_enabled,
  input  logic [CREDIT_WIDTH-1:0] i_credit_init,
  input  logic [5:0]              i_request_in,
  input  logic                    i_credit_return,
  input  logic                    i_paged_flush,
  input  logic                    i_restart_done,
  output logic [5:0]              o_grant_out,
  output logic                    o_issue_valid,
  output logic [CREDIT_WIDTH-1:0] o_credits_out,
  output logic                    o_restart_mode,
  output logic                    o_credit_error
);
  localparam int NUM_REQ = 6;
  localparam logic [CREDIT_WIDTH-1:0] PF_RES = CREDIT_WIDTH'(PREFETCH_RESERVE);
  localparam logic [CREDIT_WIDTH-1:0] ONE    = CREDIT_WIDTH'(1);

  typedef enum logic [1:0] {ARB_RESET, ARB_INIT, ARB_RUN, ARB_RESTART_ONLY} arb_state_t;

  arb_state_t              r_state, w_next;
  logic [NUM_REQ-1:0]      r_grant, w_grant, w_req;
  logic [CREDIT_WIDTH-1:0] r_credits, r_cap;
  logic                    r_rr, r_credit_error;
  logic                    w_active, w_base, w_pf_ok, w_pick_rd, w_take, w_ret_at_cap;

  always_ff @(posedge i_clock)
    if (!i_rstn) r_state <= ARB_RESET;
    else         r_state <= w_next;

  // paged_flush is tested before restart_done so it wins when both pulse together
  always_comb
    w_next = r_state == ARB_RESET ? ARB_INIT :
             r_state == ARB_INIT  ? ARB_RUN :
             i_paged_flush        ? ARB_RESTART_ONLY :
             (r_state == ARB_RESTART_ONLY && i_restart_done) ? ARB_RUN : r_state;

  always_comb begin
    o_grant_out    = r_grant;
    o_issue_valid  = |r_grant;
    o_credits_out  = r_credits;
    o_restart_mode = r_state == ARB_RESTART_ONLY;
    o_credit_error = r_credit_error;
  end

  // r_rr=0 favours write, 1 favours read; only consulted when both request
  always_comb begin
    w_active  = r_state == ARB_RUN || r_state == ARB_RESTART_ONLY;
    w_base    = w_active && i_enabled && r_credits != '0;
    w_req     = r_state == ARB_RESTART_ONLY ? {{(NUM_REQ-1){1'b0}}, i_request_in[0]} : i_request_in;
    w_pf_ok   = r_credits > PF_RES;
    w_pick_rd = w_req[3] && (!w_req[2] || r_rr);
    w_grant   = !w_base                  ? 6'b000000 :
                w_req[0]                 ? 6'b000001 :
                w_req[1]                 ? 6'b000010 :
                (w_req[2] | w_req[3])    ? (w_pick_rd ? 6'b001000 : 6'b000100) :
                (w_req[4] && w_pf_ok)    ? 6'b010000 :
                (w_req[5] && w_pf_ok)    ? 6'b100000 : 6'b000000;
    w_take       = |w_grant;
    w_ret_at_cap = !w_take && i_credit_return && r_credits == r_cap;
  end

  always_ff @(posedge i_clock)
    if (!i_rstn) begin
      r_grant        <= '0;
      r_credits      <= '0;
      r_cap          <= '0;
      r_rr           <= 1'b0;
      r_credit_error <= 1'b0;
    end else begin
      r_grant <= w_grant;
      if (r_state == ARB_INIT) begin
        r_credits <= i_credit_init;
        r_cap     <= i_credit_init;
      end else if (w_active) begin
        if (w_take && !i_credit_return)
          r_credits <= r_credits - ONE;
        else if (!w_take && i_credit_return && r_credits != r_cap)
          r_credits <= r_credits + ONE;
        if (w_ret_at_cap)
          r_credit_error <= 1'b1;
      end
      if (w_grant[2] | w_grant[3])
        r_rr <= w_grant[2];
    end
endmodule

// File: tb/tb_cmd_issue_scheduler.sv
// tb_cmd_issue_scheduler: directed vectors with hand-computed grants and credit counts.
module tb_cmd_issue_scheduler;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enabled = 1'b1;
  logic [8:0] credit_init = 9'd8;
  logic [5:0] request_in = 6'b000000;
  logic       credit_return = 1'b0;
  logic       paged_flush = 1'b0;
  logic       restart_done = 1'b0;
  logic [5:0] grant_out;
  logic       issue_valid;
  logic [8:0] credits_out;
  logic       restart_mode;
  logic       credit_error;
  int         n_checks = 0;
  int         n_errors = 0;

  cmd_issue_scheduler dut (
    .i_clock(clk), .i_rstn(rstn), .i_enabled(enabled), .i_credit_init(credit_init),
    .i_request_in(request_in), .i_credit_return(credit_return), .i_paged_flush(paged_flush),
    .i_restart_done(restart_done), .o_grant_out(grant_out), .o_issue_valid(issue_valid),
    .o_credits_out(credits_out), .o_restart_mode(restart_mode), .o_credit_error(credit_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [8:0] init);
    credit_init = init;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    // reset and credit exhaustion with write only
    request_in = 6'b000100;
    tick();
    tick();
    chk("rst_grant", grant_out, 0);
    chk("rst_valid", issue_valid, 0);
    chk("rst_credits", credits_out, 0);
    chk("rst_rmode", restart_mode, 0);
    chk("rst_err", credit_error, 0);
    rstn = 1'b1;
    tick();
    chk("init_grant", grant_out, 0);
    tick();
    chk("run_grant0", grant_out, 0);
    chk("run_credits0", credits_out, 8);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("wr_grant", grant_out, 4);
      chk("wr_credits", credits_out, 8 - k);
    end
    chk("wr_valid", issue_valid, 1);
    tick();
    chk("zero_cred_grant", grant_out, 0);
    chk("zero_cred_valid", issue_valid, 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("ret_credits", credits_out, 1);
    chk("ret_grant", grant_out, 0);
    tick();
    chk("ret_regrant", grant_out, 4);
    chk("ret_credits0", credits_out, 0);
    tick();
    chk("ret_nogrant", grant_out, 0);
    chk("no_err", credit_error, 0);

    // write/read round-robin starting with write
    request_in = 6'b001100;
    do_reset(9'd16);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", grant_out, (k % 2 == 0) ? 4 : 8);
      chk("rr_credits", credits_out, 15 - k);
    end

    // fixed priority chain, prefetch reserve
    request_in = 6'b111111;
    do_reset(9'd16);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pri_restart", grant_out, 1);
    end
    request_in = 6'b111110;
    tick();
    chk("pri_wed", grant_out, 2);
    tick();
    chk("pri_wed2", grant_out, 2);
    request_in = 6'b111100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pri_wrrd", grant_out, (k % 2 == 0) ? 4 : 8);
    end
    chk("pri_credits", credits_out, 7);
    request_in = 6'b110000;
    tick();
    chk("pf_rd_a", grant_out, 16);
    tick();
    chk("pf_rd_b", grant_out, 16);
    tick();
    chk("pf_rd_c", grant_out, 16);
    chk("pf_credits4", credits_out, 4);
    tick();
    chk("pf_reserve", grant_out, 0);
    request_in = 6'b100000;
    tick();
    chk("pf_wr_reserve", grant_out, 0);

    // prefetch_read alone at credit_init=6
    request_in = 6'b010000;
    do_reset(9'd6);
    tick();
    chk("pf6_grant", grant_out, 16);
    chk("pf6_credits", credits_out, 5);
    tick();
    chk("pf5_grant", grant_out, 16);
    chk("pf5_credits", credits_out, 4);
    tick();
    chk("pf4_grant", grant_out, 0);
    chk("pf4_credits", credits_out, 4);

    // restart-only mode
    request_in = 6'b001101;
    do_reset(9'd16);
    tick();
    chk("rm_pre_grant", grant_out, 1);
    paged_flush = 1'b1;
    tick();
    paged_flush = 1'b0;
    chk("rm_enter", restart_mode, 1);
    tick();
    chk("rm_restart", grant_out, 1);
    request_in = 6'b001100;
    tick();
    chk("rm_holdoff", grant_out, 0);
    tick();
    chk("rm_holdoff2", grant_out, 0);
    chk("rm_still", restart_mode, 1);
    restart_done = 1'b1;
    tick();
    restart_done = 1'b0;
    chk("rm_exit", restart_mode, 0);
    tick();
    chk("rm_resume_wr", grant_out, 4);
    tick();
    chk("rm_resume_rd", grant_out, 8);
    paged_flush = 1'b1;
    restart_done = 1'b1;
    tick();
    paged_flush = 1'b0;
    restart_done = 1'b0;
    chk("rm_both", restart_mode, 1);
    chk("rm_both_grant", grant_out, 4);
    tick();
    chk("rm_both_hold", grant_out, 0);

    // credit return at cap, enable gating, sticky error cleared by reset
    request_in = 6'b000000;
    do_reset(9'd8);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("cap_credits", credits_out, 8);
    chk("cap_err", credit_error, 1);
    request_in = 6'b000100;
    enabled = 1'b0;
    tick();
    chk("dis_grant", grant_out, 0);
    chk("dis_credits", credits_out, 8);
    chk("err_sticky", credit_error, 1);
    enabled = 1'b1;
    tick();
    chk("en_grant", grant_out, 4);
    rstn = 1'b0;
    tick();
    chk("err_cleared", credit_error, 0);
    chk("rst_drop_grant", grant_out, 0);
    chk("rst_credits2", credits_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
